ddr5_phy_dqs_write_gen: RTL

Write-path DQS strobe generator. It sits directly downstream of the command/address stage and consumes that stage's decoded mode-register outputs: burst length, preamble pattern and length, postamble length, and DRAM CRC enable. On each write-data start pulse it produces the DQS_t/DQS_c sequence (preamble, burst toggles, optional CRC slot, postamble), the DQS output enable, and the DQ data-valid windows. Each clk_i cycle carries 2 UI, with bit[1] first; the serializer downstream runs at 2x.

---
 rtl/ddr5_phy_pkg.sv | 42 ++++
 rtl/ddr5_phy_dqs_cycle_cnt.sv | 36 +++
 rtl/ddr5_phy_dqs_write_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ddr5_phy_pkg.sv
// Shared encodings, FSM state type and write configuration for the DDR5 PHY DQS write path.
package ddr5_phy_pkg;

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] BL_BL16 = 2'b00;
    localparam logic [1:0] BL_BC8  = 2'b01;
    localparam logic [1:0] BL_BL32 = 2'b10;

    localparam logic [1:0] POST_0P5 = 2'b01;
    localparam logic [1:0] POST_1P5 = 2'b10;

    localparam int unsigned BURST_CYC_BL16 = 8;
    localparam int unsigned BURST_CYC_BL32 = 16;
    localparam int unsigned BC8_DATA_CYC   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_BURST,
        ST_CRC,
        ST_POST
    } dqs_state_e;

    typedef struct packed {
        logic [1:0] bl;
        logic [7:0] pattern;
        logic [2:0] npre;
        logic [1:0] post;
        logic       crc_en;
    } wr_cfg_t;

    // Counter load value for the last index of a burst (cycles - 1).
    function automatic logic [CNT_W-1:0] burst_last(input logic [1:0] bl);
        return (bl == BL_BL32) ? CNT_W'(BURST_CYC_BL32 - 1) : CNT_W'(BURST_CYC_BL16 - 1);
    endfunction

    function automatic logic [CNT_W-1:0] post_last(input logic [1:0] post);
        return (post == POST_1P5) ? CNT_W'(1) : CNT_W'(0);
    endfunction

endpackage

// File: rtl/ddr5_phy_dqs_cycle_cnt.sv
// Loadable down-counter with terminal flag; sequences the PRE, BURST and POST phases.
module ddr5_phy_dqs_cycle_cnt
    import ddr5_phy_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_c,
    output logic             tc_o
);

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_nxt_c = cnt_o;
        if (load_i) begin
            cnt_nxt_c = load_val_i;
        end else if (dec_i && (cnt_o != '0)) begin
            cnt_nxt_c = cnt_o - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= cnt_nxt_c;
        end
    end

    assign tc_o = (cnt_o == '0);

endmodule

// File: rtl/ddr5_phy_dqs_write_gen.sv
// DDR5 write-path DQS strobe generator: preamble, burst toggles, optional CRC slot, postamble.
// Define DDR5_DQS_SEAMLESS_EN to accept back-to-back bursts at the last BURST (or CRC) cycle.
module ddr5_phy_dqs_write_gen
    import ddr5_phy_pkg::*;
#(
    parameter int unsigned pMAX_PRE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       wr_start_i,
    input  logic [1:0] burst_length_i,
    input  logic [7:0] pre_pattern_i,
    input  logic [2:0] num_pre_cycle_i,
    input  logic [1:0] num_post_cycle_i,
    input  logic       dram_crc_en_i,
    output logic [1:0] dqs_t_o,
    output logic [1:0] dqs_c_o,
    output logic       dqs_oe_o,
    output logic       dq_valid_o,
    output logic       crc_slot_o,
    output logic       busy_o,
    output logic       err_o
);

    dqs_state_e       state_q, state_d;
    wr_cfg_t          cfg_q, cfg_d, cfg_in;
    logic             cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0] cnt_load_val, cnt_q, cnt_d;
    logic [1:0]       dqs_t_d;
    logic             oe_d, dqv_d, crc_d, err_d;
    logic             seamless;

    // Normalise raw mode-register fields into the latched configuration form.
    always_comb begin
        cfg_in.bl      = (burst_length_i == 2'b11) ? BL_BL16 : burst_length_i;
        cfg_in.pattern = pre_pattern_i;
        if (num_pre_cycle_i == 3'd0) begin
            cfg_in.npre = 3'd1;
        end else if (32'(num_pre_cycle_i) > pMAX_PRE_CYCLES) begin
            cfg_in.npre = 3'(pMAX_PRE_CYCLES);
        end else begin
            cfg_in.npre = num_pre_cycle_i;
        end
        cfg_in.post   = (num_post_cycle_i == POST_1P5) ? POST_1P5 : POST_0P5;
        cfg_in.crc_en = dram_crc_en_i;
    end

`ifdef DDR5_DQS_SEAMLESS_EN
    assign seamless = wr_start_i &&
                      (((state_q == ST_BURST) && cnt_tc && !cfg_q.crc_en) || (state_q == ST_CRC));
`else
    assign seamless = 1'b0;
`endif

    ddr5_phy_dqs_cycle_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (enable_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_q),
        .cnt_nxt_c  (cnt_d),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE, ST_POST: begin
                if (wr_start_i) begin
                    state_d      = ST_PRE;
                    cfg_d        = cfg_in;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(cfg_in.npre - 3'd1);
                end else if (state_q == ST_POST) begin
                    if (cnt_tc) state_d = ST_IDLE;
                    else        cnt_dec = 1'b1;
                end
            end
            ST_PRE: begin
                err_d = wr_start_i;
                if (cnt_tc) begin
                    state_d      = ST_BURST;
                    cnt_load     = 1'b1;
                    cnt_load_val = burst_last(cfg_q.bl);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_BURST, ST_CRC: begin
                if (seamless) begin
                    state_d      = ST_BURST;
                    cfg_d        = cfg_in;
                    cnt_load     = 1'b1;
                    cnt_load_val = burst_last(cfg_in.bl);
                end else begin
                    err_d = wr_start_i;
                    if ((state_q == ST_BURST) && !cnt_tc) begin
                        cnt_dec = 1'b1;
                    end else if ((state_q == ST_BURST) && cfg_q.crc_en) begin
                        state_d = ST_CRC;
                    end else begin
                        state_d      = ST_POST;
                        cnt_load     = 1'b1;
                        cnt_load_val = post_last(cfg_q.post);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so that every output is registered.
    always_comb begin
        dqs_t_d = 2'b00;
        oe_d    = 1'b0;
        dqv_d   = 1'b0;
        crc_d   = 1'b0;
        case (state_d)
            ST_PRE: begin
                oe_d = 1'b1;
                case (cnt_d[1:0])
                    2'd0:    dqs_t_d = cfg_d.pattern[1:0];
                    2'd1:    dqs_t_d = cfg_d.pattern[3:2];
                    2'd2:    dqs_t_d = cfg_d.pattern[5:4];
                    default: dqs_t_d = cfg_d.pattern[7:6];
                endcase
            end
            ST_BURST: begin
                oe_d    = 1'b1;
                dqs_t_d = 2'b10;
                dqv_d   = (cfg_d.bl != BL_BC8) ||
                          (cnt_d >= CNT_W'(BURST_CYC_BL16 - BC8_DATA_CYC));
            end
            ST_CRC: begin
                oe_d    = 1'b1;
                dqs_t_d = 2'b10;
                crc_d   = 1'b1;
            end
            ST_POST: begin
                oe_d    = 1'b1;
                dqs_t_d = (cnt_d != '0) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            dqs_t_o    <= 2'b00;
            dqs_c_o    <= 2'b11;
            dqs_oe_o   <= 1'b0;
            dq_valid_o <= 1'b0;
            crc_slot_o <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else if (enable_i) begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            dqs_t_o    <= dqs_t_d;
            dqs_c_o    <= ~dqs_t_d;
            dqs_oe_o   <= oe_d;
            dq_valid_o <= dqv_d;
            crc_slot_o <= crc_d;
            busy_o     <= (state_d != ST_IDLE);
            err_o      <= err_d;
        end
    end

endmodule
